// File: rtl/vip_pkg.sv
// Shared widths, default image geometry and FSM state type for the VIP motion-mask blocks.
package vip_pkg;

  localparam int unsigned VIP_COORD_W = 10;
  localparam int unsigned VIP_CNT_W   = 19;

  localparam logic [VIP_COORD_W-1:0] VIP_IMG_HDISP  = 10'd640;
  localparam logic [VIP_COORD_W-1:0] VIP_IMG_VDISP  = 10'd480;
  localparam logic [VIP_CNT_W-1:0]   VIP_MIN_PIXELS = 19'd64;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    REPORT
  } bbox_state_t;

endpackage

// File: rtl/vip_sync_edge.sv
// Registers one copy of a sync input and flags its rising and falling edges combinationally.
module vip_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  // One-cycle delayed copy of the sync input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  // Edge pulses against the delayed copy
  always_comb begin
    rise = sig & ~sig_q;
    fall = ~sig & sig_q;
  end

endmodule

// File: rtl/vip_bit_bbox_detect.sv
// Bounding box and pixel count of all '1' pixels in a 1-bit motion mask frame.
// Results are published once per frame, one REPORT cycle after vsync falls.
// Optional macro VIP_BBOX_MIN_PIX_EN: box_found requires at least MIN_PIXELS pixels.
module vip_bit_bbox_detect
  import vip_pkg::*;
#(
  parameter logic [VIP_COORD_W-1:0] IMG_HDISP  = VIP_IMG_HDISP,
  parameter logic [VIP_COORD_W-1:0] IMG_VDISP  = VIP_IMG_VDISP,
  parameter logic [VIP_CNT_W-1:0]   MIN_PIXELS = VIP_MIN_PIXELS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   per_frame_vsync,
  input  logic                   per_frame_href,
  input  logic                   per_frame_clken,
  input  logic                   per_img_Bit,
  output logic                   box_valid,
  output logic                   box_found,
  output logic [VIP_COORD_W-1:0] box_xmin,
  output logic [VIP_COORD_W-1:0] box_xmax,
  output logic [VIP_COORD_W-1:0] box_ymin,
  output logic [VIP_COORD_W-1:0] box_ymax,
  output logic [VIP_CNT_W-1:0]   box_pix_cnt
);

  logic vs_rise, vs_fall, hs_fall, unused_hs_rise;

  vip_sync_edge u_vsync_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (per_frame_vsync),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  vip_sync_edge u_href_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (per_frame_href),
    .rise (unused_hs_rise),
    .fall (hs_fall)
  );

  bbox_state_t state_q, state_d;
  logic primed_q, armed_q, seen_q;
  logic [VIP_COORD_W-1:0] x_q, y_q, xmin_q, xmax_q, ymin_q, ymax_q;
  logic [VIP_CNT_W-1:0]   cnt_q;
  logic pix_ok, pix_one, frame_start, found_w;

  assign pix_ok  = per_frame_href & per_frame_clken;
  assign pix_one = pix_ok & per_img_Bit;
  // After reset the delayed vsync copy is 0, so a rise is trusted only once vsync has been
  // seen low; this keeps a frame already in progress at reset release from being reported.
  assign frame_start = (state_q == IDLE) && vs_rise && primed_q;

`ifdef VIP_BBOX_MIN_PIX_EN
  assign found_w = (cnt_q >= MIN_PIXELS);
`else
  logic unused_min_pixels;
  assign unused_min_pixels = ^MIN_PIXELS;
  assign found_w = (cnt_q != '0);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_start) state_d = ACTIVE;
      ACTIVE:  if (vs_fall) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame bookkeeping flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      primed_q <= primed_q | ~per_frame_vsync;
      if (frame_start) begin
        armed_q <= 1'b1;
      end else if (state_q == REPORT) begin
        armed_q <= 1'b0;
      end
    end
  end

  // Position counters and bounding box accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      seen_q <= 1'b0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      cnt_q  <= '0;
    end else if (frame_start) begin
      // Frame clear wins over a pixel arriving with the vsync rise
      x_q    <= '0;
      y_q    <= '0;
      seen_q <= 1'b0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      cnt_q  <= '0;
    end else if (state_q == ACTIVE) begin
      if (pix_ok) begin
        if (x_q != IMG_HDISP - 10'd1) x_q <= x_q + 10'd1;
      end else if (hs_fall) begin
        x_q <= '0;
        if (y_q != IMG_VDISP - 10'd1) y_q <= y_q + 10'd1;
      end
      if (pix_one) begin
        seen_q <= 1'b1;
        if (!(&cnt_q)) cnt_q <= cnt_q + 19'd1;
        if (!seen_q) begin
          xmin_q <= x_q;
          xmax_q <= x_q;
          ymin_q <= y_q;
          ymax_q <= y_q;
        end else begin
          if (x_q < xmin_q) xmin_q <= x_q;
          if (x_q > xmax_q) xmax_q <= x_q;
          if (y_q < ymin_q) ymin_q <= y_q;
          if (y_q > ymax_q) ymax_q <= y_q;
        end
      end
    end
  end

  // Result registers, loaded once per completed frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_valid   <= 1'b0;
      box_found   <= 1'b0;
      box_xmin    <= '0;
      box_xmax    <= '0;
      box_ymin    <= '0;
      box_ymax    <= '0;
      box_pix_cnt <= '0;
    end else if ((state_q == REPORT) && armed_q) begin
      box_valid   <= 1'b1;
      box_found   <= found_w;
      box_xmin    <= found_w ? xmin_q : '0;
      box_xmax    <= found_w ? xmax_q : '0;
      box_ymin    <= found_w ? ymin_q : '0;
      box_ymax    <= found_w ? ymax_q : '0;
      box_pix_cnt <= cnt_q;
    end else begin
      box_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vip_bit_bbox_detect.sv
// Self-checking bench for vip_bit_bbox_detect: table of frames plus hand-built corner sequences.
module tb_vip_bit_bbox_detect;

  logic clk = 1'b0;
  logic rst_n, vsync, href, clken, bitv;
  logic box_valid, box_found;
  logic [9:0] box_xmin, box_xmax, box_ymin, box_ymax;
  logic [18:0] box_pix_cnt;

  vip_bit_bbox_detect dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .per_frame_vsync(vsync),
    .per_frame_href (href),
    .per_frame_clken(clken),
    .per_img_Bit    (bitv),
    .box_valid      (box_valid),
    .box_found      (box_found),
    .box_xmin       (box_xmin),
    .box_xmax       (box_xmax),
    .box_ymin       (box_ymin),
    .box_ymax       (box_ymax),
    .box_pix_cnt    (box_pix_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x0, x1, y0, y1, nlines, width;
    bit has_obj, toggle;
    bit efound;
    int exmin, exmax, eymin, eymax, ecnt;
  } frame_t;

  typedef struct {
    bit found;
    int xmin, xmax, ymin, ymax, cnt, drop;
  } exp_t;

  exp_t sbq[$];
  frame_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply the found rule and coordinate masking to raw expected bounds.
  function automatic frame_t mk(input int x0, x1, y0, y1, nlines, width, input bit has_obj,
                                toggle, input int xmin, xmax, ymin, ymax, cnt);
    frame_t f;
    f.x0 = x0; f.x1 = x1; f.y0 = y0; f.y1 = y1; f.nlines = nlines; f.width = width;
    f.has_obj = has_obj; f.toggle = toggle;
    f.exmin = xmin; f.exmax = xmax; f.eymin = ymin; f.eymax = ymax; f.ecnt = cnt;
`ifdef VIP_BBOX_MIN_PIX_EN
    f.efound = (cnt >= 64);
`else
    f.efound = (cnt != 0);
`endif
    if (!f.efound) begin
      f.exmin = 0; f.exmax = 0; f.eymin = 0; f.eymax = 0;
    end
    return f;
  endfunction

  // Scoreboard consumer: every box_valid pops one expected result.
  exp_t mon_e;
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_prev) check("valid_one_cycle", int'(box_valid), 0);
      if (box_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got box_valid=1 at cycle %0d expected no report", cyc);
        end else begin
          mon_e = sbq.pop_front();
          check("found", int'(box_found), int'(mon_e.found));
          check("xmin", int'(box_xmin), mon_e.xmin);
          check("xmax", int'(box_xmax), mon_e.xmax);
          check("ymin", int'(box_ymin), mon_e.ymin);
          check("ymax", int'(box_ymax), mon_e.ymax);
          check("pix_cnt", int'(box_pix_cnt), mon_e.cnt);
          check("latency", cyc - mon_e.drop, 2);
        end
      end
    end
    valid_prev = box_valid;
  end

  // Drive one cycle of inputs (called right after a negedge).
  task automatic drive(input bit v, input bit h, input bit c, input bit b);
    vsync = v; href = h; clken = c; bitv = b;
    @(negedge clk);
  endtask

  task automatic push_exp(input frame_t f);
    exp_t e;
    e.found = f.efound; e.xmin = f.exmin; e.xmax = f.exmax;
    e.ymin = f.eymin; e.ymax = f.eymax; e.cnt = f.ecnt; e.drop = cyc;
    sbq.push_back(e);
  endtask

  task automatic run_frame(input frame_t f);
    bit in_y, in_x;
    int w;
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    for (int y = 0; y < f.nlines; y++) begin
      in_y = (y >= f.y0) && (y <= f.y1);
      w = in_y ? f.width : 1;
      for (int i = 0; i < w; i++) begin
        in_x = (i >= f.x0) && (i <= f.x1);
        drive(1, 1, 1, f.has_obj && in_y && in_x);
        if (f.toggle) drive(1, 1, 0, 1);
      end
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
    end
    push_exp(f);
    drive(0, 0, 0, 0);
    repeat (6) drive(0, 0, 0, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, int'(box_valid), 0);
    check({tag, "_found"}, int'(box_found), 0);
    check({tag, "_xmin"}, int'(box_xmin), 0);
    check({tag, "_xmax"}, int'(box_xmax), 0);
    check({tag, "_ymin"}, int'(box_ymin), 0);
    check({tag, "_ymax"}, int'(box_ymax), 0);
    check({tag, "_cnt"}, int'(box_pix_cnt), 0);
  endtask

  initial begin
    frame_t f;
    int budget;
    //         x0   x1   y0   y1   lines width obj tog  xmin xmax ymin ymax cnt
    tbl.push_back(mk(100, 100, 50, 50, 52, 101, 1, 0, 100, 100, 50, 50, 1));
    tbl.push_back(mk(200, 239, 300, 319, 321, 240, 1, 0, 200, 239, 300, 319, 800));
    tbl.push_back(mk(0, 19, 1, 3, 5, 20, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(10, 12, 2, 3, 5, 13, 1, 1, 10, 12, 2, 3, 6));
    tbl.push_back(mk(635, 700, 1, 1, 3, 705, 1, 0, 635, 639, 1, 1, 66));
    tbl.push_back(mk(3, 3, 478, 485, 490, 4, 1, 0, 3, 3, 478, 479, 8));
    tbl.push_back(mk(20, 26, 5, 11, 12, 27, 1, 0, 20, 26, 5, 11, 49));
    tbl.push_back(mk(30, 39, 5, 14, 15, 40, 1, 0, 30, 39, 5, 14, 100));

    rst_n = 1'b0; vsync = 0; href = 0; clken = 0; bitv = 0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (3) drive(0, 0, 0, 0);

    foreach (tbl[i]) run_frame(tbl[i]);

    // vsync rise alongside a qualifying pixel drops it; vsync fall during href keeps it
    drive(1, 1, 1, 1);
    drive(1, 1, 1, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0);
    f = mk(0, 0, 0, 0, 0, 0, 1, 0, 4, 4, 1, 1, 1);
    push_exp(f);
    drive(0, 1, 1, 1);
    repeat (6) drive(0, 0, 0, 0);

    // Reset in the middle of a frame: that frame must never be reported
    run_frame(tbl[1]);
    drive(1, 0, 0, 0);
    for (int y = 0; y < 240; y++) begin
      drive(1, 1, 1, 0);
      drive(1, 0, 0, 0);
    end
    rst_n = 1'b0;
    repeat (3) drive(1, 0, 0, 0);
    check_outputs_zero("midreset");
    rst_n = 1'b1;
    for (int y = 0; y < 20; y++) begin
      for (int i = 0; i < 30; i++) drive(1, 1, 1, (i == 5));
      drive(1, 0, 0, 0);
    end
    drive(0, 0, 0, 0);
    repeat (10) drive(0, 0, 0, 0);
    check_outputs_zero("after_partial");

    // Next full frame reports normally
    run_frame(tbl[0]);

    budget = 0;
    while (sbq.size() != 0 && budget < 200) begin
      drive(0, 0, 0, 0);
      budget++;
    end
    check("pending_reports", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
